// File: rtl/regfile_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler_if
//
// Bundles the writeback-side signals of the register file write scheduler.
//
//   master : the pipeline / memory side. It drives the ALU request, the load
//            return and BUSYWAIT, and it observes the grant, ready, count and
//            register-file write outputs.
//   slave  : the scheduler itself.
//
// Signals:
//   BUSYWAIT      memory stall; no write is granted while high
//   ALU_WRITE     ALU writeback request, held until granted
//   ALU_ADDR      ALU destination register
//   ALU_DATA      ALU result
//   ALU_GRANT     ALU write accepted this cycle (combinational)
//   ALU_STALL     ALU request pending but not granted (combinational)
//   MEM_VALID     load data return valid
//   MEM_ADDR      load destination register
//   MEM_DATA      load data
//   MEM_READY     load FIFO can accept an entry
//   RF_WRITE      register file WRITE (registered)
//   RF_INADDRESS  register file INADDRESS (registered)
//   RF_IN         register file IN (registered)
//   FIFO_COUNT    occupied FIFO entries, squashed entries included
// ---------------------------------------------------------------------------
interface regfile_write_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              BUSYWAIT;
  logic              ALU_WRITE;
  logic [ADDR_W-1:0] ALU_ADDR;
  logic [DATA_W-1:0] ALU_DATA;
  logic              ALU_GRANT;
  logic              ALU_STALL;
  logic              MEM_VALID;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DATA;
  logic              MEM_READY;
  logic              RF_WRITE;
  logic [ADDR_W-1:0] RF_INADDRESS;
  logic [DATA_W-1:0] RF_IN;
  logic [CNT_W-1:0]  FIFO_COUNT;

  modport master (
    output BUSYWAIT, ALU_WRITE, ALU_ADDR, ALU_DATA,
    output MEM_VALID, MEM_ADDR, MEM_DATA,
    input  ALU_GRANT, ALU_STALL, MEM_READY,
    input  RF_WRITE, RF_INADDRESS, RF_IN, FIFO_COUNT
  );

  modport slave (
    input  BUSYWAIT, ALU_WRITE, ALU_ADDR, ALU_DATA,
    input  MEM_VALID, MEM_ADDR, MEM_DATA,
    output ALU_GRANT, ALU_STALL, MEM_READY,
    output RF_WRITE, RF_INADDRESS, RF_IN, FIFO_COUNT
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_write_scheduler
//
// Shares the register file's single write port between the ALU writeback
// path and load data returned by the data cache. Load returns go into a
// small in-order FIFO. The ALU normally wins, but an aging counter forces a
// valid FIFO head through after MAX_WAIT consecutive ALU wins. An ALU write
// invalidates (squashes) every buffered load to the same register, so an
// older load can never overwrite a younger ALU result. Squashed entries still
// occupy their slot until they reach the head, where they are dropped
// without using the port.
//
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RESET  synchronous, active-high; empties the FIFO and clears the outputs
//   bus    regfile_write_scheduler_if.slave (see the interface for signals)
//
// Parameters:
//   DATA_W    register data width
//   ADDR_W    register index width
//   DEPTH     load FIFO entries (power of two, >= 2)
//   MAX_WAIT  consecutive ALU wins a valid FIFO head tolerates
// ---------------------------------------------------------------------------
module regfile_write_scheduler #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input logic                     CLK,
  input logic                     RESET,
  regfile_write_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] MAX_WAIT_C = AGE_W'(MAX_WAIT);

  // Outcome of the port arbitration for the current cycle.
  typedef enum logic [2:0] {
    WIN_NONE,      // port idle
    WIN_DROP,      // squashed head discarded, port idle
    WIN_DROP_ALU,  // squashed head discarded, ALU uses the port
    WIN_LOAD,      // FIFO head uses the port
    WIN_ALU        // ALU uses the port, FIFO head (if any) waits
  } win_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  valid_next;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [AGE_W-1:0]  age_reg;
  logic [AGE_W-1:0]  age_next;

  logic              rf_write_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  win_e              win;
  logic              head_present;
  logic              head_valid;
  logic              fifo_ready;
  logic              pop;
  logic              alu_win;
  logic              load_win;
  logic              enq;
  logic              enq_valid;

  assign head_present = (count_reg != '0);
  assign head_valid   = valid_reg[head_reg];
  assign fifo_ready   = (count_reg < DEPTH_C);

  always_comb begin
    win = WIN_NONE;
    if (!RESET && !bus.BUSYWAIT) begin
      if (head_present && !head_valid) begin
        // A squashed head costs nothing: drop it and let the ALU go too.
        win = bus.ALU_WRITE ? WIN_DROP_ALU : WIN_DROP;
      end else if (head_present && (age_reg == MAX_WAIT_C || !bus.ALU_WRITE)) begin
        win = WIN_LOAD;
      end else if (bus.ALU_WRITE) begin
        win = WIN_ALU;
      end
    end
  end

  assign pop      = (win == WIN_DROP) || (win == WIN_DROP_ALU) || (win == WIN_LOAD);
  assign alu_win  = (win == WIN_ALU)  || (win == WIN_DROP_ALU);
  assign load_win = (win == WIN_LOAD);

  // Age only accumulates while a valid head is being passed over by the ALU;
  // any pop restarts it for the next head.
  always_comb begin
    age_next = age_reg;
    if (pop) begin
      age_next = '0;
    end else if (win == WIN_ALU && head_present && age_reg != MAX_WAIT_C) begin
      age_next = age_reg + AGE_W'(1);
    end
  end

  // Enqueue is independent of BUSYWAIT. A load arriving at the same edge as
  // an ALU grant to the same register is the older write, so it is stored
  // already squashed.
  assign enq       = bus.MEM_VALID && fifo_ready && !RESET;
  assign enq_valid = !(alu_win && (bus.MEM_ADDR == bus.ALU_ADDR));

  assign count_next = count_reg + CNT_W'(enq) - CNT_W'(pop);

  // -------------------------------------------------------------------------
  // Per-entry valid bit: a new entry takes enq_valid, an ALU grant to the
  // entry's register clears it. Slots outside the occupied range are never
  // read, so popped entries need no clearing.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic is_tail;
      logic squash_hit;

      assign is_tail    = (tail_reg == PTR_W'(gi));
      assign squash_hit = alu_win && (addr_mem[gi] == bus.ALU_ADDR);

      always_comb begin
        valid_next[gi] = valid_reg[gi];
        if (enq && is_tail) begin
          valid_next[gi] = enq_valid;
        end else if (squash_hit) begin
          valid_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (enq) begin
      addr_mem[tail_reg] <= bus.MEM_ADDR;
      data_mem[tail_reg] <= bus.MEM_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      age_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      age_reg   <= age_next;
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (enq) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file write port. Address and data hold when nothing wins.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rf_write_reg <= 1'b0;
      rf_addr_reg  <= '0;
      rf_data_reg  <= '0;
    end else begin
      rf_write_reg <= load_win || alu_win;
      if (load_win) begin
        rf_addr_reg <= addr_mem[head_reg];
        rf_data_reg <= data_mem[head_reg];
      end else if (alu_win) begin
        rf_addr_reg <= bus.ALU_ADDR;
        rf_data_reg <= bus.ALU_DATA;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ALU_GRANT    = alu_win;
  assign bus.ALU_STALL    = bus.ALU_WRITE && !bus.BUSYWAIT && !alu_win;
  // The FIFO is being emptied during reset, so it advertises space.
  assign bus.MEM_READY    = RESET || fifo_ready;
  assign bus.RF_WRITE     = rf_write_reg;
  assign bus.RF_INADDRESS = rf_addr_reg;
  assign bus.RF_IN        = rf_data_reg;
  assign bus.FIFO_COUNT   = count_reg;

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Arbitrates the register file's single write port between two writeback sources: the ALU result path and load data returned by the data cache. Cache load returns are buffered in a small in-order FIFO. The ALU has priority, but an aging counter prevents load starvation. A later ALU write squashes any older buffered load to the same register, which preserves write-after-write order. Sits between the execute/memory stages and the register file write port (IN/INADDRESS/WRITE).

Parameters:
DATA_W, 8, data width of a register
ADDR_W, 3, register index width (8 registers)
DEPTH, 2, load-return FIFO entries (power of 2, >=2)
MAX_WAIT, 3, consecutive ALU-won cycles a valid FIFO head tolerates before it is forced through

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high
BUSYWAIT  in  1  memory stall; when high no write is granted
ALU_WRITE  in  1  ALU writeback request (held by pipeline until granted)
ALU_ADDR  in  ADDR_W  destination register of ALU write
ALU_DATA  in  DATA_W  ALU result
ALU_GRANT  out  1  combinational; ALU write accepted this cycle
ALU_STALL  out  1  combinational; ALU_WRITE & !BUSYWAIT & !ALU_GRANT
MEM_VALID  in  1  load data return valid
MEM_ADDR  in  ADDR_W  destination register of load
MEM_DATA  in  DATA_W  load data
MEM_READY  out  1  FIFO count < DEPTH (from registered count)
RF_WRITE  out  1  registered; drives register file WRITE
RF_INADDRESS  out  ADDR_W  registered; drives INADDRESS
RF_IN  out  DATA_W  registered; drives IN
FIFO_COUNT  out  log2(DEPTH)+1  occupied entries, including squashed ones

Behaviour:
- Reset (RESET high at posedge): FIFO emptied (count=0, pointers=0, all valid bits 0), age=0, RF_WRITE=0, RF_INADDRESS=0, RF_IN=0. Reset mid-operation discards buffered loads with no write. During reset MEM_READY=1 and ALU_GRANT=0.
- Enqueue: MEM_VALID & MEM_READY at posedge writes {valid=1, addr, data} at tail. Enqueue is permitted while BUSYWAIT=1. MEM_VALID with MEM_READY=0 is ignored; the source must hold it.
- There is no bypass. A load enqueued at edge N can win at edge N+1 at the earliest, so RF_WRITE for it is high from edge N+1 to edge N+2.
- Head selection, evaluated only when BUSYWAIT=0:
  - Squashed head (valid=0): popped this cycle, no port use, age cleared. The ALU may be granted in the same cycle.
  - Valid head with (age==MAX_WAIT or ALU_WRITE=0): load wins. RF regs load the head entry, RF_WRITE=1, head popped, age=0, ALU_GRANT=0.
  - Otherwise, if ALU_WRITE=1: ALU wins. ALU_GRANT=1, RF regs load the ALU entry, RF_WRITE=1. If a valid head exists, age increments (saturates at MAX_WAIT).
  - No winner: RF_WRITE=0. RF_INADDRESS and RF_IN hold their values.
- BUSYWAIT=1: RF_WRITE=0 next cycle, no pop, age holds, ALU_GRANT=0, ALU_STALL=0.
- Squash: on ALU grant with address A, every FIFO entry with addr==A gets valid cleared at that edge. A load enqueued at the same edge with MEM_ADDR==A is treated as older and is enqueued with valid=0.
- Pop and enqueue at the same edge are allowed. Count is unchanged and the pointers wrap modulo DEPTH.
- RF_WRITE is a single-cycle pulse per grant. Back-to-back grants hold it high on consecutive cycles with new address/data each cycle.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles -> RF_WRITE=0, RF_IN=0, FIFO_COUNT=0, MEM_READY=1. Assert RESET with 2 entries queued -> count=0 next cycle, no RF_WRITE.
- ALU only: ALU_WRITE=1, ADDR=1, DATA=30 -> ALU_GRANT=1 same cycle. Next cycle RF_WRITE=1, RF_INADDRESS=1, RF_IN=30 for exactly one cycle.
- Load only: MEM_VALID one cycle, ADDR=6, DATA=45, FIFO empty, no ALU -> FIFO_COUNT=1. One edge later RF_WRITE=1, addr 6, data 45, and count returns to 0.
- Starvation: one load queued (addr 2) and ALU_WRITE held to addr 3 for 6 cycles with MAX_WAIT=3 -> ALU wins 3 cycles, load wins the 4th (ALU_STALL=1 that cycle), then ALU resumes.
- Squash: queue loads r5=12, r4=7, then ALU write r5=90 while BUSYWAIT=0 and ALU_WRITE held -> only r5=90 and r4=7 reach the port. The r5=12 entry pops silently.
- Full/busy: BUSYWAIT=1, enqueue 2 loads -> MEM_READY=0, a 3rd MEM_VALID is ignored, no RF_WRITE. Drop BUSYWAIT -> two writes on consecutive cycles, MEM_READY=1 after the first pop.
